// File: rtl/shreg_sched_pkg.sv
// Shared types and width helpers for the shift-register scheduler.
// Widths are derived from the instantiating module's parameters through constant functions.
package shreg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        FIN
    } state_t;

    // The bit counter must hold WIDTH+DEPTH without wrapping.
    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/shreg_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after the pointer, wrapping.
// The pointer register is owned by the instantiating scheduler.
module rr_arbiter
    import shreg_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_j;

    // NOTE: every output gets a default before the search, so no path leaves a latch behind.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = 0;
        if (i_en) begin
            for (int i = 0; i < NREQ; i++) begin
                w_j = (int'(i_ptr) + i) % NREQ;
                if (!o_valid && i_req[w_j]) begin
                    o_gnt[w_j] = 1'b1;
                    o_idx      = IDX_W'(w_j);
                    o_valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/shreg_sched.sv
// Arbitrates requesters for a tick-paced shift-register datapath: grant, serialise LSB-first,
// flush DEPTH stages, then pulse done to the owner. All outputs are registered.
module shreg_sched
    import shreg_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       data,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic                        busy,
    output logic [idx_width(NREQ)-1:0]  owner,
    output logic                        sr_en,
    output logic                        sr_din
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int CNT_W = cnt_width(WIDTH, DEPTH);

    state_t             r_state,  w_state_nxt;
    logic [NREQ-1:0]    r_gnt,    w_gnt_nxt;
    logic [NREQ-1:0]    r_done,   w_done_nxt;
    logic               r_busy,   w_busy_nxt;
    logic [IDX_W-1:0]   r_owner,  w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr,    w_ptr_nxt;
    logic [WIDTH-1:0]   r_buf,    w_buf_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic               r_sr_en,  w_sr_en_nxt;
    logic               r_sr_din, w_sr_din_nxt;

    logic [NREQ-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic [WIDTH-1:0]   w_word;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .i_en    (r_state == IDLE),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_word = data[w_arb_idx*WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = '0;
        w_done_nxt   = '0;
        w_busy_nxt   = (r_state != IDLE);
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_buf_nxt    = r_buf;
        w_cnt_nxt    = r_cnt;
        w_sr_en_nxt  = 1'b0;
        w_sr_din_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_gnt_nxt   = w_arb_gnt;
                    w_buf_nxt   = w_word;
                    w_owner_nxt = w_arb_idx;
                    w_ptr_nxt   = (w_arb_idx == IDX_W'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A tick landing in the grant cycle (gnt still high) does not count.
                if (tick && !(|r_gnt)) begin
                    w_sr_en_nxt  = 1'b1;
                    w_sr_din_nxt = r_buf[0];
                    w_buf_nxt    = r_buf >> 1;
                    w_cnt_nxt    = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tick) begin
                    w_sr_en_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH + DEPTH - 1)) begin
                        w_state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                w_done_nxt[r_owner] = 1'b1;
                w_state_nxt         = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_sr_en  <= 1'b0;
            r_sr_din <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_owner  <= w_owner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sr_en  <= w_sr_en_nxt;
            r_sr_din <= w_sr_din_nxt;
        end
    end

    // NOTE: the data buffer is left out of reset; it is always reloaded at grant before any bit is read.
    always_ff @(posedge clk) begin
        r_buf <= w_buf_nxt;
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = r_busy;
    assign owner  = r_owner;
    assign sr_en  = r_sr_en;
    assign sr_din = r_sr_din;

endmodule

// File: tb/tb_shreg_sched.sv
// Directed bench for shreg_sched: arbitration order, serialisation, drain, latency and reset abort.
// Outputs are sampled 1 time unit after each rising edge and logged for the checks.
module tb_shreg_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic [NREQ-1:0]   req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [1:0]        owner;
    logic              sr_en;
    logic              sr_din;

    shreg_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .req    (req),
        .data   (data),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .owner  (owner),
        .sr_en  (sr_en),
        .sr_din (sr_din)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int p_bit[$];
    int p_cyc[$];
    int g_val[$];
    int g_cyc[$];
    int d_val[$];
    int d_cyc[$];
    logic [7:0] w [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        cyc++;
        if (sr_en) begin
            p_bit.push_back(int'(sr_din));
            p_cyc.push_back(cyc);
        end
        if (|gnt) begin
            g_val.push_back(int'(gnt));
            g_cyc.push_back(cyc);
        end
        if (|done) begin
            d_val.push_back(int'(done));
            d_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        p_bit.delete();
        p_cyc.delete();
        g_val.delete();
        g_cyc.delete();
        d_val.delete();
        d_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
    endtask

    // Packs logged serial bits [first, first+n) into a word, first bit at position 0.
    function automatic logic [31:0] bits_from(input int first, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (first + i < p_bit.size()) v[i] = p_bit[first + i][0];
        end
        return v;
    endfunction

    task automatic run_until_done(input string tag, input int period, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            step((i % period) == period - 1);
            if (|done) begin
                got = 1;
                break;
            end
        end
        check({tag, "_timeout"}, got, 1);
    endtask

    initial begin
        int adj;
        w[0] = 8'hA5;
        w[1] = 8'hC3;
        w[2] = 8'h3C;
        w[3] = 8'h96;
        data = {w[3], w[2], w[1], w[0]};
        tick = 1'b0;
        req  = '0;

        // Reset values
        rst = 1'b1;
        step(1'b0);
        step(1'b1);
        check("reset_outputs", {gnt, done, busy, owner, sr_en, sr_din}, '0);
        rst = 1'b0;

        // Test 1: single request, tick every 4 cycles
        clear_log();
        req = 4'b0001;
        step(1'b0);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy_at_gnt", busy, 1'b0);
        req  = '0;
        data = {w[3], w[2], w[1], 8'hFF};
        step(1'b0);
        check("t1_gnt_pulse_one_cycle", gnt, '0);
        check("t1_busy_after_gnt", busy, 1'b1);
        run_until_done("t1", 4, 300);
        check("t1_pulse_count", p_bit.size(), WIDTH + DEPTH);
        check("t1_bits", bits_from(0, 10), 32'h0A5);
        check("t1_done", done, 4'b0001);
        check("t1_busy_at_done", busy, 1'b1);
        check("t1_done_latency", (p_cyc.size() > 0) ? cyc - p_cyc[p_cyc.size() - 1] : -1, 1);
        adj = 0;
        for (int i = 1; i < p_cyc.size(); i++) if (p_cyc[i] == p_cyc[i - 1] + 1) adj = 1;
        check("t1_no_adjacent_pulses", adj, 0);
        step(1'b0);
        check("t1_busy_low_after", busy, 1'b0);
        check("t1_done_cleared", done, '0);
        data = {w[3], w[2], w[1], w[0]};

        // Test 2: everyone requesting, rotation 0,1,2,3,0
        do_reset();
        clear_log();
        req = 4'b1111;
        for (int i = 0; i < 2000 && d_val.size() < 5; i++) step((i % 2) == 1);
        req = '0;
        check("t2_done_count", d_val.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_gnt_order_%0d", k), (k < g_val.size()) ? g_val[k] : -1, 1 << (k % 4));
            check($sformatf("t2_done_owner_%0d", k), (k < d_val.size()) ? d_val[k] : -1, 1 << (k % 4));
            check($sformatf("t2_bits_%0d", k), bits_from(10 * k, 10), {24'h0, w[k % 4]});
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_done_to_gnt_%0d", k),
                  (k + 1 < g_cyc.size() && k < d_cyc.size()) ? g_cyc[k + 1] - d_cyc[k] : -1, 1);
        end
        check("t2_pulse_total", p_bit.size(), 5 * (WIDTH + DEPTH));
        step(1'b0);

        // Test 3: tick coinciding with the gnt cycle is ignored
        do_reset();
        clear_log();
        req = 4'b0100;
        step(1'b0);
        check("t3_gnt", gnt, 4'b0100);
        req = '0;
        step(1'b1);
        check("t3_gnt_tick_ignored", sr_en, 1'b0);
        step(1'b0);
        step(1'b0);
        check("t3_no_early_pulse", p_bit.size(), 0);
        step(1'b1);
        check("t3_first_pulse", sr_en, 1'b1);
        run_until_done("t3", 3, 300);
        check("t3_pulse_count", p_bit.size(), WIDTH + DEPTH);
        check("t3_bits", bits_from(0, 10), 32'h03C);

        // Test 4: reset mid-transfer
        do_reset();
        clear_log();
        req = 4'b0001;
        step(1'b0);
        req = '0;
        for (int i = 0; i < 100 && p_bit.size() < 3; i++) step((i % 2) == 1);
        check("t4_three_pulses", p_bit.size(), 3);
        rst = 1'b1;
        step(1'b1);
        check("t4_abort_outputs", {gnt, done, busy, sr_en}, '0);
        rst = 1'b0;
        req = 4'b0010;
        step(1'b0);
        check("t4_regrant", gnt, 4'b0010);
        check("t4_owner", owner, 2'd1);
        req = '0;
        run_until_done("t4", 1, 200);
        check("t4_done_owner", done, 4'b0010);
        check("t4_single_done", d_val.size(), 1);

        // Test 5: idle ticks, then a late request held off until FIN
        clear_log();
        for (int i = 0; i < 6; i++) step(1'b1);
        check("t5_idle_no_pulses", p_bit.size(), 0);
        check("t5_idle_busy", busy, 1'b0);
        req = 4'b0001;
        step(1'b0);
        check("t5_gnt0", gnt, 4'b0001);
        req = 4'b0100;
        run_until_done("t5", 2, 300);
        check("t5_done0", done, 4'b0001);
        check("t5_held_off", g_val.size(), 1);
        step(1'b0);
        check("t5_gnt2", gnt, 4'b0100);
        check("t5_done_to_gnt", (g_cyc.size() > 1) ? g_cyc[1] - d_cyc[0] : -1, 1);
        req = '0;

        // Test 6: ticks every cycle give back-to-back pulses
        clear_log();
        run_until_done("t6", 1, 200);
        check("t6_pulse_count", p_bit.size(), WIDTH + DEPTH);
        check("t6_consecutive", (p_cyc.size() > 0) ? p_cyc[p_cyc.size() - 1] - p_cyc[0] : -1, 9);
        check("t6_bits", bits_from(0, 10), 32'h03C);
        check("t6_done", done, 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shreg_sched.md
Name: shreg_sched

Overview:
- Arbitrates NREQ requesters for one shared tick-paced, enabled shift-register datapath (din/en → dout → doutf chain, DEPTH stages).
- Grants one requester, captures its WIDTH-bit word and serialises it LSB-first into the datapath, one bit per tick.
- Flushes the DEPTH-stage pipe, then signals completion to the owner.
- Sits between the tick generator and the shift-register FSM. It replaces the hard-wired en=1/din tie-off.

Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, bits per transfer (≥1)
- DEPTH, 2, datapath pipeline stages to flush after the last data bit (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pacing pulse from the clock-enable generator
- req  in  NREQ  request per requester; level, sampled in IDLE only
- data  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot, one-cycle pulse; data captured that cycle
- done  out  NREQ  one-hot, one-cycle pulse to the owner at end of transfer
- busy  out  1  high from the cycle after gnt until done, inclusive
- owner  out  $clog2(NREQ)  index of the current or last granted requester
- sr_en  out  1  datapath enable, one-cycle pulse
- sr_din  out  1  datapath serial data, valid when sr_en=1

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - The round-robin pointer gives requester 0 top priority.
  - Reset mid-transfer aborts the transfer immediately with no done pulse. Captured data is discarded.
- All outputs are registered.
- State machine IDLE → SHIFT → DRAIN → FIN → IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit starting at the pointer and wrapping modulo NREQ.
  - Pulse gnt[k] in the same cycle. Load the word into the shift buffer. Set owner=k and the pointer to (k+1) mod NREQ.
  - Go to SHIFT.
  - No req set: stay in IDLE, all outputs hold 0. Ticks in IDLE are ignored.
- SHIFT:
  - On each cycle with tick=1, the next cycle has sr_en=1 and sr_din = buffer LSB. The buffer shifts right and the bit counter increments.
  - After WIDTH pulses, go to DRAIN.
- DRAIN:
  - On each tick, the next cycle has sr_en=1 and sr_din=0.
  - After DEPTH pulses, go to FIN.
- FIN:
  - Lasts one cycle: done[owner]=1 and busy=1.
  - Next cycle: IDLE, where arbitration may grant again immediately.
- sr_en is never high on two consecutive cycles unless tick was high on two consecutive cycles. Every tick in SHIFT/DRAIN yields exactly one pulse.
- Each transfer produces exactly WIDTH+DEPTH sr_en pulses.
- Latency:
  - First sr_en arrives one cycle after the first tick strictly after the gnt cycle. A tick coinciding with gnt is ignored.
  - done follows the last sr_en pulse by one cycle.
- Req changes during SHIFT/DRAIN/FIN are ignored. Data is not re-sampled after gnt.
- A requester that drops req before being granted is never granted.
- With all requesters requesting continuously, grants rotate 0,1,…,NREQ-1,0.
- Bit counter width is $clog2(WIDTH+DEPTH+1). It never wraps within a transfer.

Decomposition:
- Package shreg_sched_pkg holds:
  - the state enum (IDLE, SHIFT, DRAIN, FIN)
  - counter-width and index-width localparams as functions of WIDTH, DEPTH and NREQ
- One sub-module: rr_arbiter (NREQ). Inputs: req, pointer, enable. Outputs: one-hot grant and encoded index. Purely combinational; the pointer register lives in shreg_sched.

Test Plan:
- Single request, tick every 4 cycles: req=0001, data0=8'hA5.
  - gnt=0001 for one cycle.
  - 10 sr_en pulses carry sr_din 1,0,1,0,0,1,0,1 then 0,0.
  - done=0001 one cycle after the 10th pulse. busy low the following cycle.
- All requesting, req=1111 held: grants in order 0,1,2,3,0 across five back-to-back transfers. Each done precedes the next gnt by exactly one cycle.
- Tick coincides with gnt: tick at the gnt cycle is ignored. First sr_en appears one cycle after the next tick. The pulse count is still 10.
- Reset mid-transfer: assert rst after the 3rd sr_en pulse.
  - Next cycle: gnt, done, busy, sr_en all 0; state IDLE.
  - No done pulse for the aborted owner.
  - After release with req=0010, requester 1 is granted (pointer reset to 0, first set bit).
- Ticks with no requests, then late request: ticks while idle give sr_en=0. Requester 2 raising req while 0 is in SHIFT is held off until FIN completes, then granted.
- Back-to-back ticks every cycle: sr_en is high on consecutive cycles. Exactly WIDTH+DEPTH=10 pulses. Data matches the captured word LSB-first.
